gpio_port: RTL and testbench



---
 rtl/gpio_pkg.sv | 14 +
 rtl/gpio_sync_edge.sv | 31 +++
 rtl/gpio_port.sv | 102 ++++++++++
 tb/tb_gpio_port.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the gpio_port peripheral: register offsets and default geometry.
package gpio_pkg;

    localparam int unsigned GPIO_WIDTH  = 13;
    localparam int unsigned GPIO_DATA_W = 64;
    localparam int unsigned GPIO_ADDR_W = 6;

    localparam logic [2:0] GPIO_DIR  = 3'd0;
    localparam logic [2:0] GPIO_OUT  = 3'd1;
    localparam logic [2:0] GPIO_IN   = 3'd2;
    localparam logic [2:0] GPIO_EDGE = 3'd3;
    localparam logic [2:0] GPIO_IE   = 3'd4;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop pin synchroniser with a previous-sample register for rising-edge detection.
module gpio_sync_edge #(
    parameter int unsigned WIDTH = 13
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= pin_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign level = sync2;
    assign rise  = sync2 & ~prev;

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO block: direction/output registers, synchronised inputs,
// sticky rising-edge flags with interrupt enable, and a one-cycle registered read port.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH  = GPIO_WIDTH,
    parameter int unsigned DATA_W = GPIO_DATA_W,
    parameter int unsigned ADDR_W = GPIO_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cs,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [WIDTH-1:0]  pin_in,
    output logic [WIDTH-1:0]  pin_out,
    output logic [WIDTH-1:0]  pin_oe,
    output logic              irq
);

    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] ie_q;

    logic [WIDTH-1:0] in_level;
    logic [WIDTH-1:0] in_rise;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_val;
    logic [2:0]       sel;
    logic             wr_en;
    logic             rd_en;
    logic             unused_bits;

    // Simultaneous read and write strobes are treated as no access at all.
    assign wr_en   = cs & mem_write & ~mem_read;
    assign rd_en   = cs & mem_read & ~mem_write;
    assign sel     = address[5:3];
    assign wr_data = data_in[WIDTH-1:0];

    assign unused_bits = ^{data_in[DATA_W-1:WIDTH], address[2:0]};

    gpio_sync_edge #(
        .WIDTH (WIDTH)
    ) u_sync_edge (
        .clock  (clock),
        .reset  (reset),
        .pin_in (pin_in),
        .level  (in_level),
        .rise   (in_rise)
    );

    assign edge_clr = (wr_en && (sel == GPIO_EDGE)) ? wr_data : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dir_q  <= '0;
            out_q  <= '0;
            ie_q   <= '0;
            edge_q <= '0;
        end else begin
            if (wr_en && (sel == GPIO_DIR)) dir_q <= wr_data;
            if (wr_en && (sel == GPIO_OUT)) out_q <= wr_data;
            if (wr_en && (sel == GPIO_IE))  ie_q  <= wr_data;
            // A rise in the same cycle as its clear keeps the flag set.
            edge_q <= (edge_q & ~edge_clr) | in_rise;
        end
    end

    // Read mux; unmapped offsets return zero.
    always_comb begin
        rd_val = '0;
        case (sel)
            GPIO_DIR:  rd_val = dir_q;
            GPIO_OUT:  rd_val = out_q;
            GPIO_IN:   rd_val = in_level;
            GPIO_EDGE: rd_val = edge_q;
            GPIO_IE:   rd_val = ie_q;
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
            data_oe  <= 1'b0;
        end else begin
            data_oe <= rd_en;
            if (rd_en) data_out <= DATA_W'(rd_val);
        end
    end

    assign pin_oe  = dir_q;
    assign pin_out = out_q;
    assign irq     = |(edge_q & ie_q);

endmodule

// File: tb/tb_gpio_port.sv
// Directed self-checking bench for gpio_port: register access, input sync, edge flags, irq, reset.
module tb_gpio_port;

    localparam int unsigned WIDTH  = 13;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 6;

    localparam logic [5:0] A_DIR  = 6'd0;
    localparam logic [5:0] A_OUT  = 6'd8;
    localparam logic [5:0] A_IN   = 6'd16;
    localparam logic [5:0] A_EDGE = 6'd24;
    localparam logic [5:0] A_IE   = 6'd32;

    logic              clock;
    logic              reset;
    logic              cs;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic [WIDTH-1:0]  pin_in;
    logic [WIDTH-1:0]  pin_out;
    logic [WIDTH-1:0]  pin_oe;
    logic              irq;

    int n_cmp = 0;
    int n_err = 0;

    gpio_port #(
        .WIDTH  (WIDTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cs        (cs),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .pin_in    (pin_in),
        .pin_out   (pin_out),
        .pin_oe    (pin_oe),
        .irq       (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [63:0] d);
        address = a; data_in = d; cs = 1'b1; mem_write = 1'b1; mem_read = 1'b0;
        tick();
        cs = 1'b0; mem_write = 1'b0; data_in = '0;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [63:0] d, output logic oe);
        address = a; cs = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        tick();
        cs = 1'b0; mem_read = 1'b0;
        d = data_out; oe = data_oe;
    endtask

    task automatic test_reset();
        logic [63:0] d;
        logic        oe;
        logic [5:0]  offs [5];
        offs = '{A_DIR, A_OUT, A_IN, A_EDGE, A_IE};
        n_cmp++; if (pin_oe !== 13'h0) begin n_err++; $display("FAIL rst_pin_oe got %h want 0000", pin_oe); end
        n_cmp++; if (pin_out !== 13'h0) begin n_err++; $display("FAIL rst_pin_out got %h want 0000", pin_out); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b want 0", irq); end
        n_cmp++; if (data_oe !== 1'b0) begin n_err++; $display("FAIL rst_data_oe got %b want 0", data_oe); end
        reset = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus_read(offs[i], d, oe);
            n_cmp++; if (d !== 64'h0) begin n_err++; $display("FAIL rst_read%0d got %h want 0", i, d); end
            n_cmp++; if (oe !== 1'b1) begin n_err++; $display("FAIL rst_read_oe%0d got %b want 1", i, oe); end
            tick();
            n_cmp++; if (data_oe !== 1'b0) begin n_err++; $display("FAIL rst_oe_drop%0d got %b want 0", i, data_oe); end
        end
    endtask

    task automatic test_write();
        logic [63:0] d;
        logic        oe;
        bus_write(A_DIR, 64'h1FFF);
        n_cmp++; if (pin_oe !== 13'h1FFF) begin n_err++; $display("FAIL wr_dir got %h want 1fff", pin_oe); end
        bus_write(A_OUT, 64'h0A5A);
        n_cmp++; if (pin_out !== 13'h0A5A) begin n_err++; $display("FAIL wr_out got %h want 0a5a", pin_out); end
        bus_write(A_OUT, 64'hFFFF_FFFF_FFFF_0123);
        n_cmp++; if (pin_out !== 13'h0123) begin n_err++; $display("FAIL wr_out_trunc got %h want 0123", pin_out); end
        bus_read(A_OUT, d, oe);
        n_cmp++; if (d !== 64'h0000_0000_0000_0123) begin n_err++; $display("FAIL rd_out got %h want 123", d); end
        bus_read(A_DIR, d, oe);
        n_cmp++; if (d !== 64'h1FFF) begin n_err++; $display("FAIL rd_dir got %h want 1fff", d); end
        bus_write(A_IE, 64'h0001);
        bus_read(A_IE, d, oe);
        n_cmp++; if (d !== 64'h0001) begin n_err++; $display("FAIL rd_ie got %h want 1", d); end
    endtask

    task automatic test_edge();
        logic [63:0] d;
        logic        oe;
        pin_in = 13'h1B9B;
        tick();
        bus_read(A_IN, d, oe);
        n_cmp++; if (d !== 64'h0) begin n_err++; $display("FAIL in_early got %h want 0", d); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early got %b want 0", irq); end
        bus_read(A_IN, d, oe);
        n_cmp++; if (d !== 64'h1B9B) begin n_err++; $display("FAIL in_sync got %h want 1b9b", d); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rise got %b want 1", irq); end
        bus_read(A_EDGE, d, oe);
        n_cmp++; if (d !== 64'h1B9B) begin n_err++; $display("FAIL edge_set got %h want 1b9b", d); end
    endtask

    task automatic test_w1c();
        logic [63:0] d;
        logic        oe;
        bus_write(A_EDGE, 64'h1B98);
        bus_read(A_EDGE, d, oe);
        n_cmp++; if (d !== 64'h0003) begin n_err++; $display("FAIL edge_w1c_a got %h want 3", d); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_hold got %b want 1", irq); end
        bus_write(A_EDGE, 64'h0001);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_fall got %b want 0", irq); end
        bus_read(A_EDGE, d, oe);
        n_cmp++; if (d !== 64'h0002) begin n_err++; $display("FAIL edge_w1c_b got %h want 2", d); end
        // Drop pin 1, let it settle, then raise it so its rise lands on the clearing write.
        pin_in = 13'h1B99;
        repeat (4) tick();
        pin_in = 13'h1B9B;
        tick();
        tick();
        bus_write(A_EDGE, 64'h0002);
        bus_read(A_EDGE, d, oe);
        n_cmp++; if (d !== 64'h0002) begin n_err++; $display("FAIL edge_set_wins got %h want 2", d); end
        bus_write(A_EDGE, 64'h0002);
        bus_read(A_EDGE, d, oe);
        n_cmp++; if (d !== 64'h0000) begin n_err++; $display("FAIL edge_clear got %h want 0", d); end
    endtask

    task automatic test_illegal();
        logic [63:0] d;
        logic        oe;
        address = A_OUT; data_in = 64'h1FFF; cs = 1'b1; mem_read = 1'b1; mem_write = 1'b1;
        tick();
        cs = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        n_cmp++; if (data_oe !== 1'b0) begin n_err++; $display("FAIL illegal_oe got %b want 0", data_oe); end
        n_cmp++; if (pin_out !== 13'h0123) begin n_err++; $display("FAIL illegal_out got %h want 0123", pin_out); end
        bus_write(A_IN, 64'h1FFF);
        bus_write(6'd48, 64'h1FFF);
        bus_read(A_IN, d, oe);
        n_cmp++; if (d !== 64'h1B9B) begin n_err++; $display("FAIL in_ro got %h want 1b9b", d); end
        bus_read(6'd13, d, oe);
        n_cmp++; if (d !== 64'h0123) begin n_err++; $display("FAIL addr_low_ign got %h want 123", d); end
        bus_read(A_IE, d, oe);
        n_cmp++; if (d !== 64'h0001) begin n_err++; $display("FAIL ie_kept got %h want 1", d); end
        n_cmp++; if (pin_oe !== 13'h1FFF) begin n_err++; $display("FAIL dir_kept got %h want 1fff", pin_oe); end
        for (int i = 5; i < 8; i++) begin
            bus_read(6'(i * 8), d, oe);
            n_cmp++; if (d !== 64'h0) begin n_err++; $display("FAIL unmapped%0d got %h want 0", i, d); end
            n_cmp++; if (oe !== 1'b1) begin n_err++; $display("FAIL unmapped_oe%0d got %b want 1", i, oe); end
        end
    endtask

    task automatic test_back_to_back();
        address = A_DIR; cs = 1'b1; mem_read = 1'b1;
        tick();
        n_cmp++; if (data_oe !== 1'b1 || data_out !== 64'h1FFF) begin n_err++; $display("FAIL b2b_0 got oe=%b d=%h want oe=1 d=1fff", data_oe, data_out); end
        address = A_OUT;
        tick();
        n_cmp++; if (data_oe !== 1'b1 || data_out !== 64'h0123) begin n_err++; $display("FAIL b2b_1 got oe=%b d=%h want oe=1 d=123", data_oe, data_out); end
        cs = 1'b0; mem_read = 1'b0;
        tick();
        n_cmp++; if (data_oe !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b want 0", data_oe); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        logic        oe;
        logic [5:0]  offs [5];
        offs = '{A_DIR, A_OUT, A_IN, A_EDGE, A_IE};
        pin_in = 13'h0000;
        repeat (4) tick();
        pin_in = 13'h0004;
        repeat (4) tick();
        bus_read(A_EDGE, d, oe);
        n_cmp++; if (d !== 64'h0004 || oe !== 1'b1) begin n_err++; $display("FAIL pend_edge got oe=%b d=%h want oe=1 d=4", oe, d); end
        #2;
        reset = 1'b0;
        pin_in = 13'h0000;
        #1;
        n_cmp++; if (data_oe !== 1'b0) begin n_err++; $display("FAIL async_oe got %b want 0", data_oe); end
        n_cmp++; if (data_out !== 64'h0) begin n_err++; $display("FAIL async_dout got %h want 0", data_out); end
        n_cmp++; if (pin_oe !== 13'h0 || pin_out !== 13'h0) begin n_err++; $display("FAIL async_pins got oe=%h out=%h want 0", pin_oe, pin_out); end
        tick();
        reset = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            bus_read(offs[i], d, oe);
            n_cmp++; if (d !== 64'h0) begin n_err++; $display("FAIL post_rst%0d got %h want 0", i, d); end
        end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL post_rst_irq got %b want 0", irq); end
    endtask

    initial begin
        reset = 1'b0; cs = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        address = '0; data_in = '0; pin_in = '0;
        #13;
        test_reset();
        test_write();
        test_edge();
        test_w1c();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
